// File: rtl/puf_crp_verifier.sv
// Verifier-side controller for the arbiter-PUF array. It walks an LFSR challenge sequence,
// fires the race pulse, and either enrolls the responses or scores them by Hamming distance.
module puf_crp_verifier #(
  parameter int NUM_CRP    = 16,
  parameter int SETTLE_CYC = 4,
  parameter int PULSE_CYC  = 4,
  parameter int HD_W       = 8
) (
  input  logic            iclk,
  input  logic            irst,
  input  logic            istart,
  input  logic            imode,
  input  logic [7:0]      iseed,
  input  logic [HD_W-1:0] ithreshold,
  input  logic [7:0]      iresponse,
  output logic [7:0]      ochallenge,
  output logic            opulse,
  output logic            obusy,
  output logic            odone,
  output logic            opass,
  output logic            oerr,
  output logic [HD_W-1:0] ohd,
  output logic            oenrolled
);

  // state  | meaning
  // IDLE   | waiting for istart
  // SETUP  | challenge stable, pulse low
  // FIRE   | race pulse high
  // SYNC   | pulse low, response crossing the synchronizer
  // SAMPLE | store or score the synchronized response
  // DONE   | one-cycle end-of-run strobe
  typedef enum logic [2:0] {IDLE, SETUP, FIRE, SYNC, SAMPLE, DONE} state_t;

  localparam int CW = 16;
  localparam int KW = (NUM_CRP > 1) ? $clog2(NUM_CRP) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic [7:0]      lfsr_q, lfsr_d, lfsr_step;
  logic [7:0]      chal_q, chal_d;
  logic            mode_q, mode_d;
  logic [HD_W-1:0] thr_q, thr_d;
  logic [HD_W-1:0] hd_q, hd_d;
  logic            pass_q, pass_d;
  logic            err_q, err_d;
  logic            enr_q, enr_d;
  logic [7:0]      sync1_q, sync2_q;
  logic [7:0]      mem_q [NUM_CRP];
  logic            mem_we;
  logic [7:0]      diff;
  logic [3:0]      pc;
  logic [HD_W:0]   hd_sum;
  logic [7:0]      seed_fix;

  assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign seed_fix  = (iseed == 8'h00) ? 8'h01 : iseed;

  always_comb begin
    diff = sync2_q ^ mem_q[k_q];
    pc   = 4'd0;
    for (int i = 0; i < 8; i++) pc = pc + 4'(diff[i]);
    hd_sum = {1'b0, hd_q} + (HD_W+1)'(pc);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    lfsr_d  = lfsr_q;
    chal_d  = chal_q;
    mode_d  = mode_q;
    thr_d   = thr_q;
    hd_d    = hd_q;
    pass_d  = pass_q;
    err_d   = err_q;
    enr_d   = enr_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: if (istart) begin
        mode_d = imode;
        thr_d  = ithreshold;
        k_d    = '0;
        hd_d   = '0;
        pass_d = 1'b0;
        err_d  = 1'b0;
        if (imode && !enr_q) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          lfsr_d  = seed_fix;
          chal_d  = seed_fix;
          cnt_d   = CW'(SETTLE_CYC - 1);
          if (!imode) enr_d = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: if (cnt_q == '0) begin
        cnt_d   = CW'(PULSE_CYC - 1);
        state_d = FIRE;
      end else cnt_d = cnt_q - 1'b1;
      FIRE: if (cnt_q == '0) begin
        cnt_d   = CW'(1);
        state_d = SYNC;
      end else cnt_d = cnt_q - 1'b1;
      SYNC: if (cnt_q == '0) state_d = SAMPLE;
            else cnt_d = cnt_q - 1'b1;
      SAMPLE: begin
        if (!mode_q) mem_we = 1'b1;
        else hd_d = hd_sum[HD_W] ? '1 : hd_sum[HD_W-1:0];
        lfsr_d = lfsr_step;
        k_d    = k_q + 1'b1;
        // Results are settled on entry to DONE so they are valid alongside odone.
        if (k_q == KW'(NUM_CRP - 1)) begin
          state_d = DONE;
          if (!mode_q) enr_d = 1'b1;
          else pass_d = (hd_d <= thr_q);
        end else begin
          chal_d  = lfsr_step;
          cnt_d   = CW'(SETTLE_CYC - 1);
          state_d = SETUP;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      lfsr_q  <= 8'h01;
      chal_q  <= 8'h00;
      mode_q  <= 1'b0;
      thr_q   <= '0;
      hd_q    <= '0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
      enr_q   <= 1'b0;
      sync1_q <= 8'h00;
      sync2_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      lfsr_q  <= lfsr_d;
      chal_q  <= chal_d;
      mode_q  <= mode_d;
      thr_q   <= thr_d;
      hd_q    <= hd_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      enr_q   <= enr_d;
      sync1_q <= iresponse;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge iclk) begin
    if (mem_we) mem_q[k_q] <= sync2_q;
  end

  assign ochallenge = chal_q;
  assign opulse     = (state_q == FIRE);
  assign obusy      = (state_q != IDLE);
  assign odone      = (state_q == DONE);
  assign opass      = pass_q;
  assign oerr       = err_q;
  assign ohd        = hd_q;
  assign oenrolled  = enr_q;

endmodule

// File: tb/tb_puf_crp_verifier.sv
// Directed bench for puf_crp_verifier: PUF modelled as challenge ^ 0xFF, optional bit-0 flip.
module tb_puf_crp_verifier;
  logic       iclk = 1'b0;
  logic       irst, istart, imode;
  logic [7:0] iseed, ithreshold, iresponse;
  logic [7:0] ochallenge, ohd;
  logic       opulse, obusy, odone, opass, oerr, oenrolled;
  logic       flip;

  int compared = 0;
  int mismatched = 0;

  puf_crp_verifier dut (
    .iclk(iclk), .irst(irst), .istart(istart), .imode(imode), .iseed(iseed),
    .ithreshold(ithreshold), .iresponse(iresponse), .ochallenge(ochallenge),
    .opulse(opulse), .obusy(obusy), .odone(odone), .opass(opass), .oerr(oerr),
    .ohd(ohd), .oenrolled(oenrolled)
  );

  always #5 iclk = ~iclk;
  assign iresponse = ochallenge ^ 8'hFF ^ {7'b0, flip};

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Starts a run and follows it to odone, recording timing and the first three challenges.
  task automatic do_run(input logic mode, input logic [7:0] seed, input logic [7:0] thr,
                        input int glitch_at, output int len, output int pulses,
                        output int busy, output logic [7:0] ch0, output logic [7:0] ch1,
                        output logic [7:0] ch2, output int bad_chg, output logic pass_d,
                        output logic err_d);
    logic [7:0] prev;
    int nch;
    imode = mode; iseed = seed; ithreshold = thr; istart = 1'b1;
    tick();
    istart = 1'b0;
    len = 0; pulses = 0; busy = 0; bad_chg = 0; nch = 1;
    ch0 = ochallenge; ch1 = 8'hxx; ch2 = 8'hxx; prev = ochallenge;
    pass_d = 1'bx; err_d = 1'bx;
    while (!odone && len < 1000) begin
      if (obusy) busy++;
      if (opulse) pulses++;
      if (len == glitch_at) istart = 1'b1;
      tick();
      istart = 1'b0;
      len++;
      if (ochallenge !== prev) begin
        if (opulse) bad_chg++;
        if (nch == 1) ch1 = ochallenge;
        if (nch == 2) ch2 = ochallenge;
        nch++;
        prev = ochallenge;
      end
    end
    if (obusy) busy++;
    pass_d = opass; err_d = oerr;
    tick();
  endtask

  int len, pulses, busy, bad;
  logic [7:0] c0, c1, c2;
  logic pd, ed;

  initial begin
    irst = 1'b1; istart = 1'b0; imode = 1'b0; iseed = 8'h00; ithreshold = 8'h00; flip = 1'b0;
    tick(); tick();
    irst = 1'b0;
    check("rst_outs", {ochallenge, opulse, obusy, odone, opass, oerr, oenrolled, ohd}, 32'h0);

    imode = 1'b1; istart = 1'b1;
    tick();
    istart = 1'b0;
    check("err_done", {odone, oerr, opass}, 32'b110);
    tick();
    check("err_after", {odone, obusy, oerr}, 32'b001);

    do_run(1'b0, 8'h5A, 8'h00, -1, len, pulses, busy, c0, c1, c2, bad, pd, ed);
    check("enr_ch0", c0, 32'h5A);
    check("enr_ch1", c1, 32'hB4);
    check("enr_ch2", c2, 32'h69);
    check("enr_len", len, 176);
    check("enr_busy", busy, 177);
    check("enr_pulses", pulses, 64);
    check("enr_chg_in_pulse", bad, 0);
    check("enr_enrolled", oenrolled, 1);
    check("enr_idle", {obusy, odone}, 0);

    do_run(1'b1, 8'h5A, 8'h00, -1, len, pulses, busy, c0, c1, c2, bad, pd, ed);
    check("auth0_hd", ohd, 0);
    check("auth0_pass", pd, 1);
    check("auth0_err", ed, 0);
    check("auth0_len", len, 176);

    flip = 1'b1;
    do_run(1'b1, 8'h5A, 8'd15, -1, len, pulses, busy, c0, c1, c2, bad, pd, ed);
    check("auth15_hd", ohd, 16);
    check("auth15_pass", pd, 0);
    do_run(1'b1, 8'h5A, 8'd16, -1, len, pulses, busy, c0, c1, c2, bad, pd, ed);
    check("auth16_hd", ohd, 16);
    check("auth16_pass", pd, 1);
    check("auth16_hold", opass, 1);
    flip = 1'b0;

    do_run(1'b0, 8'h00, 8'h00, -1, len, pulses, busy, c0, c1, c2, bad, pd, ed);
    check("seed0_ch0", c0, 32'h01);
    check("seed0_ch1", c1, 32'h02);

    do_run(1'b0, 8'h5A, 8'h00, 30, len, pulses, busy, c0, c1, c2, bad, pd, ed);
    check("glitch_len", len, 176);
    check("glitch_idle", obusy, 0);

    imode = 1'b0; iseed = 8'h5A; istart = 1'b1;
    tick();
    istart = 1'b0;
    check("mid_enr_cleared", oenrolled, 0);
    repeat (50) tick();
    irst = 1'b1;
    tick();
    irst = 1'b0;
    check("mid_rst", {obusy, oenrolled, opulse, ochallenge}, 32'h0);

    imode = 1'b1; istart = 1'b1;
    tick();
    istart = 1'b0;
    check("mid_auth_err", {odone, oerr, opass}, 32'b110);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
